poll_tx: RTL and testbench

Poll-command transmitter and transaction sequencer for the single-wire game controller link. It periodically (or on software trigger) drives the 24-bit poll command `0x4003_0r` onto the open-drain data line. It then opens a response window by asserting `ready` to the downstream button-reader stage, which counts falling edges and samples button bits only while `ready` is high. Software controls it through an APB3 slave.

---
 rtl/poll_tx_if.sv | 13 +
 rtl/poll_tx.sv | 135 +++++++++++++
 tb/tb_poll_tx.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/poll_tx_if.sv
// poll_tx_if: APB3 slave bus bundle for the poll-command transmitter
interface poll_tx_if;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
   modport slave (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/poll_tx.sv
// poll_tx: sends the 24-bit controller poll command and opens the response window
module poll_tx #(
   parameter int CLK_PER_US = 100,
   parameter int RESP_US    = 300,
   parameter int PERIOD_RST = 16000
) (
   input  logic     PCLK,
   input  logic     PRESERN,
   poll_tx_if.slave apb,
   output logic     data_oe,
   output logic     ready,
   output logic     busy
);
   // one shared phase timer and the period timer, both wide enough for a full period or window
   localparam int WW = $clog2(((RESP_US > 65535) ? RESP_US : 65535) * CLK_PER_US + 1);
   localparam logic [WW-1:0] CELL_END = WW'(4 * CLK_PER_US - 1);
   localparam logic [WW-1:0] STOP_END = WW'(CLK_PER_US - 1);
   localparam logic [WW-1:0] RESP_END = WW'(RESP_US * CLK_PER_US - 1);
   localparam logic [WW-1:0] LOW_ONE  = WW'(CLK_PER_US);
   localparam logic [WW-1:0] LOW_ZERO = WW'(3 * CLK_PER_US);

   typedef enum logic [2:0] {IDLE, TX, STOP, RESP, WAIT} state_t;

   state_t          st_q, st_d;
   logic [WW-1:0]   tm_q, tm_d, rem_q, rem_d;
   logic [4:0]      bit_q, bit_d;
   logic [15:0]     cnt_q, cnt_d, per_q, per_d;
   logic            en_q, en_d, rmb_q, rmb_d, rl_q, rl_d;
   logic            oe_q, oe_d, rdy_q, rdy_d, busy_q, busy_d;
   logic            wr, wr_ctrl, trig, go, bit_v;
   logic [23:0]     cmd;
   logic            unused_apb;

   assign wr         = apb.PSEL & apb.PENABLE & apb.PWRITE;
   assign wr_ctrl    = wr & (apb.PADDR[3:2] == 2'd0);
   assign trig       = wr_ctrl & apb.PWDATA[2];
   assign en_d       = wr_ctrl ? apb.PWDATA[0] : en_q;
   assign rmb_d      = wr_ctrl ? apb.PWDATA[1] : rmb_q;
   assign per_d      = (wr & (apb.PADDR[3:2] == 2'd1)) ? apb.PWDATA[15:0] : per_q;
   assign unused_apb = ^{apb.PADDR[31:4], apb.PADDR[1:0], apb.PWDATA[31:16]};

   assign apb.PRDATA  = !apb.PSEL ? 32'd0 :
                        (apb.PADDR[3:2] == 2'd0) ? {30'd0, rmb_q, en_q} :
                        (apb.PADDR[3:2] == 2'd1) ? {16'd0, per_q} :
                        (apb.PADDR[3:2] == 2'd2) ? {cnt_q, 14'd0, rdy_q, busy_q} : 32'd0;
   assign apb.PREADY  = 1'b1;
   assign apb.PSLVERR = 1'b0;

   assign data_oe = oe_q;
   assign ready   = rdy_q;
   assign busy    = busy_q;

   // sequencer next state; line outputs are derived from the next state so they leave a flop
   always_comb begin
      st_d  = st_q;
      tm_d  = '0;
      bit_d = bit_q;
      rl_d  = rl_q;
      cnt_d = cnt_q;
      rem_d = (rem_q == '0) ? '0 : rem_q - 1'b1;
      go    = 1'b0;
      case (st_q)
         IDLE: go = en_d | trig;
         TX: begin
            tm_d = (tm_q == CELL_END) ? '0 : tm_q + 1'b1;
            if (tm_q == CELL_END) begin
               bit_d = (bit_q == 5'd23) ? 5'd0 : bit_q + 1'b1;
               st_d  = (bit_q == 5'd23) ? STOP : TX;
            end
         end
         STOP: begin
            tm_d = (tm_q == STOP_END) ? '0 : tm_q + 1'b1;
            st_d = (tm_q == STOP_END) ? RESP : STOP;
         end
         RESP: begin
            tm_d = tm_q + 1'b1;
            if (tm_q == RESP_END) begin
               tm_d  = '0;
               cnt_d = cnt_q + 1'b1;
               st_d  = en_d ? WAIT : IDLE;
               go    = en_d & (rem_q == '0);
            end
         end
         WAIT: if (rem_q == '0) begin
            st_d = IDLE;
            go   = en_d;
         end
         default: st_d = IDLE;
      endcase
      // every TX entry restarts the bit sequence, latches rumble and rearms the period timer
      if (go) begin
         st_d  = TX;
         tm_d  = '0;
         bit_d = '0;
         rl_d  = rmb_d;
         rem_d = (per_q == 16'd0) ? '0 : WW'(per_q) * WW'(CLK_PER_US) - 1'b1;
      end
      cmd    = {23'h200180, rl_d};
      bit_v  = cmd[5'd23 - bit_d];
      oe_d   = (st_d == STOP) | ((st_d == TX) & (tm_d < (bit_v ? LOW_ONE : LOW_ZERO)));
      rdy_d  = (st_d == RESP);
      busy_d = (st_d == TX) | (st_d == STOP) | (st_d == RESP);
   end

   // state, timers, registers and registered line outputs
   always_ff @(posedge PCLK) begin
      if (!PRESERN) begin
         st_q   <= IDLE;
         tm_q   <= '0;
         rem_q  <= '0;
         bit_q  <= '0;
         cnt_q  <= '0;
         per_q  <= 16'(PERIOD_RST);
         en_q   <= 1'b0;
         rmb_q  <= 1'b0;
         rl_q   <= 1'b0;
         oe_q   <= 1'b0;
         rdy_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         tm_q   <= tm_d;
         rem_q  <= rem_d;
         bit_q  <= bit_d;
         cnt_q  <= cnt_d;
         per_q  <= per_d;
         en_q   <= en_d;
         rmb_q  <= rmb_d;
         rl_q   <= rl_d;
         oe_q   <= oe_d;
         rdy_q  <= rdy_d;
         busy_q <= busy_d;
      end
   end
endmodule

// File: tb/tb_poll_tx.sv
// tb_poll_tx: randomized bench for poll_tx against a timeline model of each transaction
module tb_poll_tx;
   localparam int T  = 4;
   localparam int RU = 20;
   localparam int L  = (97 + RU) * T;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic data_oe, ready, busy;
   poll_tx_if bus();

   poll_tx #(.CLK_PER_US(T), .RESP_US(RU)) dut (
      .PCLK(clk), .PRESERN(rstn), .apb(bus), .data_oe(data_oe), .ready(ready), .busy(busy));

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic to_fail(input string nm);
      total++;
      bad++;
      $display("FAIL timeout %s at %0t", nm, $time);
   endtask

   // model: a transaction is a start cycle plus fixed offsets; registers are plain values
   int unsigned cyc = 0;
   int unsigned m_st = 0;
   int unsigned m_plat = 0;
   bit m_on = 0, m_act = 0, m_wait = 0, m_en = 0, m_rmb = 0, m_rl = 0;
   logic [15:0] m_per = 16'd16000;
   logic [15:0] m_cnt = 16'd0;

   always @(posedge clk) begin
      bit wr, wc, trig, en_n, rmb_n, ended;
      cyc++;
      wr = bus.PSEL & bus.PENABLE & bus.PWRITE;
      wc = wr && bus.PADDR[3:2] == 2'd0;
      if (!rstn) begin
         m_on = 1; m_act = 0; m_wait = 0; m_en = 0; m_rmb = 0; m_per = 16'd16000; m_cnt = 0;
      end else begin
         trig  = wc && bus.PWDATA[2];
         en_n  = wc ? bus.PWDATA[0] : m_en;
         rmb_n = wc ? bus.PWDATA[1] : m_rmb;
         ended = 0;
         if (m_act && cyc - m_st == L) begin
            m_act = 0; m_cnt++; ended = 1; m_wait = en_n;
         end
         if (!m_act) begin
            if (m_wait) begin
               if (cyc >= m_st + m_plat * T) begin
                  m_wait = 0;
                  if (en_n) begin m_act = 1; m_st = cyc; m_rl = rmb_n; m_plat = m_per; end
               end
            end else if (!ended && (en_n || trig)) begin
               m_act = 1; m_st = cyc; m_rl = rmb_n; m_plat = m_per;
            end
         end
         m_en = en_n;
         m_rmb = rmb_n;
         if (wr && bus.PADDR[3:2] == 2'd1) m_per = bus.PWDATA[15:0];
      end
   end

   // every cycle: line outputs and read data against the model
   always @(negedge clk) begin
      int unsigned j;
      logic [23:0] cm;
      logic e_oe, e_rdy;
      logic [31:0] e_rd;
      if (m_on) begin
         j = cyc - m_st;
         cm = 24'h400300 | {23'd0, m_rl};
         e_rdy = m_act && j >= 97 * T;
         if (m_act && j < 96 * T) e_oe = (j % (4 * T)) < (cm[23 - j / (4 * T)] ? T : 3 * T);
         else e_oe = m_act && j < 97 * T;
         e_rd = !bus.PSEL ? 32'd0 :
                bus.PADDR[3:2] == 2'd0 ? {30'd0, m_rmb, m_en} :
                bus.PADDR[3:2] == 2'd1 ? {16'd0, m_per} :
                bus.PADDR[3:2] == 2'd2 ? {m_cnt, 14'd0, e_rdy, m_act} : 32'd0;
         chk("data_oe", {31'd0, data_oe}, {31'd0, e_oe});
         chk("ready", {31'd0, ready}, {31'd0, e_rdy});
         chk("busy", {31'd0, busy}, {31'd0, m_act});
         chk("prdata", bus.PRDATA, e_rd);
      end
   end

   // waveform recorder: low-phase lengths, ready widths, TX start and ready fall cycles
   int ncyc = 0, lowrun = 0, rdyrun = 0;
   bit p_oe = 0, p_rdy = 0, p_busy = 0;
   int lows[$], rdy_lens[$], st_cyc[$], rdy_fall[$];

   always @(negedge clk) begin
      ncyc++;
      if (data_oe && !p_oe && (!p_busy || p_rdy)) st_cyc.push_back(ncyc);
      if (data_oe) lowrun++;
      else if (p_oe) begin lows.push_back(lowrun); lowrun = 0; end
      if (ready) rdyrun++;
      else if (p_rdy) begin rdy_lens.push_back(rdyrun); rdy_fall.push_back(ncyc); rdyrun = 0; end
      p_oe = data_oe; p_rdy = ready; p_busy = busy;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
      tick;
      bus.PSEL = 1; bus.PWRITE = 1; bus.PENABLE = 0; bus.PADDR = a; bus.PWDATA = d;
      tick;
      bus.PENABLE = 1;
      tick;
      bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0;
   endtask

   task automatic apb_rd(input logic [31:0] a, output logic [31:0] d);
      tick;
      bus.PSEL = 1; bus.PWRITE = 0; bus.PENABLE = 0; bus.PADDR = a;
      tick;
      bus.PENABLE = 1;
      @(negedge clk);
      d = bus.PRDATA;
      tick;
      bus.PSEL = 0; bus.PENABLE = 0;
   endtask

   task automatic wait_idle(input string nm, input int lim);
      int n = 0;
      while (busy && n < lim) begin tick; n++; end
      if (busy) to_fail(nm);
   endtask

   task automatic wait_starts(input string nm, input int target, input int lim);
      int n = 0;
      while (st_cyc.size() < target && n < lim) begin tick; n++; end
      if (st_cyc.size() < target) to_fail(nm);
   endtask

   task automatic clear_rec;
      lows.delete(); rdy_lens.delete(); st_cyc.delete(); rdy_fall.delete();
   endtask

   function automatic logic [23:0] decode();
      logic [23:0] c = '0;
      for (int i = 0; i < 24 && i < lows.size(); i++) c = {c[22:0], lows[i] == T};
      return c;
   endfunction

   initial begin
      logic [31:0] rd, c0;
      bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 0; bus.PWDATA = 0;
      repeat (3) tick;
      apb_rd(32'h8, rd); chk("rst_status", rd, 32'h0);
      apb_rd(32'h4, rd); chk("rst_period", rd, 32'd16000);
      rstn = 1;
      // reset in the middle of TX releases the line on the next edge
      apb_wr(32'h0, 32'h4);
      repeat (49) tick;
      rstn = 0;
      tick;
      @(negedge clk);
      chk("midrst_oe", {31'd0, data_oe}, 32'd0);
      chk("midrst_ready", {31'd0, ready}, 32'd0);
      apb_rd(32'h8, rd); chk("midrst_status", rd, 32'h0);
      apb_rd(32'h4, rd); chk("midrst_period", rd, 32'd16000);
      rstn = 1;
      tick;
      clear_rec;
      // single trigger, rumble 0
      apb_wr(32'h0, 32'h4);
      wait_idle("trig0", 1000);
      repeat (5) tick;
      chk("t0_nlows", lows.size(), 25);
      if (lows.size() >= 25) begin
         chk("t0_low0", lows[0], 12);
         chk("t0_low1", lows[1], 4);
         chk("t0_stop", lows[24], 4);
      end
      chk("t0_cmd", {8'd0, decode()}, 32'h400300);
      chk("t0_ready_len", rdy_lens.size() > 0 ? rdy_lens[0] : 0, 80);
      apb_rd(32'h8, rd); chk("t0_status", rd, 32'h0001_0000);
      apb_rd(32'h0, rd); chk("t0_ctrl", rd, 32'h0);
      // rumble
      clear_rec;
      apb_wr(32'h0, 32'h6);
      wait_idle("rumble", 1000);
      repeat (5) tick;
      if (lows.size() >= 25) chk("rm_last_low", lows[23], 4);
      else to_fail("rm_nlows");
      chk("rm_cmd", {8'd0, decode()}, 32'h400301);
      apb_rd(32'h0, rd); chk("rm_ctrl", rd, 32'h2);
      // random triggers, rumble changes and ignored triggers mid-transaction
      for (int i = 0; i < 5; i++) begin
         apb_wr(32'h0, 32'h4 | ($urandom_range(0, 1) << 1));
         repeat ($urandom_range(0, 450)) tick;
         apb_wr(32'h0, ($urandom_range(0, 1) << 2) | ($urandom_range(0, 1) << 1));
         wait_idle("rand", 2000);
         repeat ($urandom_range(1, 20)) tick;
      end
      // periodic polling
      apb_wr(32'h4, 32'd150);
      apb_rd(32'h8, c0);
      clear_rec;
      apb_wr(32'h0, 32'h1);
      wait_starts("periodic", 4, 3000);
      for (int k = 1; k < 4 && k < st_cyc.size(); k++) chk("period_gap", st_cyc[k] - st_cyc[k - 1], 600);
      apb_rd(32'h8, rd); chk("period_cnt", {16'd0, rd[31:16] - c0[31:16]}, 32'd3);
      // back-to-back once PERIOD=0 has been latched
      apb_wr(32'h4, 32'd0);
      wait_starts("b2b", 6, 3000);
      if (st_cyc.size() >= 6 && rdy_fall.size() > 0) begin
         chk("b2b_gap", st_cyc[5] - st_cyc[4], L);
         chk("b2b_after_ready", st_cyc[5], rdy_fall[$]);
      end
      // enable cleared mid-TX, trigger during RESP ignored
      lows.delete(); rdy_lens.delete();
      apb_rd(32'h8, c0);
      repeat (100) tick;
      apb_wr(32'h0, 32'h0);
      begin
         int n = 0;
         while (!ready && n < 1000) begin tick; n++; end
         if (!ready) to_fail("wait_resp");
      end
      apb_wr(32'h0, 32'h4);
      wait_idle("disable", 1000);
      repeat (20) tick;
      chk("dis_nlows", lows.size(), 25);
      chk("dis_ready_len", rdy_lens.size() > 0 ? rdy_lens[0] : 0, 80);
      chk("dis_idle_busy", {31'd0, busy}, 32'd0);
      chk("dis_no_restart", st_cyc.size(), 6);
      apb_rd(32'h8, rd); chk("dis_cnt", {16'd0, rd[31:16] - c0[31:16]}, 32'd1);
      // APB odds and ends
      apb_rd(32'hC, rd); chk("rd_0xC", rd, 32'h0);
      apb_rd(32'h0, rd); chk("ctrl_trig_bit", rd & 32'h4, 32'h0);
      tick;
      bus.PADDR = 32'h8;
      @(negedge clk);
      chk("prdata_nosel", bus.PRDATA, 32'h0);
      tick;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
